drive_sequencer: RTL

//  Schedules the car's two-wheel motor driver between two requesters: the IR trigger (forward run)
//  and the obstacle sensor (escape: reverse, then spin). Owns the run enable / gogo direction pins,

---
 rtl/car_pkg.sv | 22 ++
 rtl/drive_sequencer_if.sv | 24 ++
 rtl/drive_sequencer_sync_2ff.sv | 34 +++
 rtl/drive_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared types and constants for the drive sequencer: state encoding and motor pin patterns.
package car_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    DEAD = 3'd2,
    BACK = 3'd3,
    TURN = 3'd4
  } state_t;

  // H-bridge direction patterns
  localparam logic [3:0] GOGO_OFF  = 4'b1111;
  localparam logic [3:0] GOGO_FWD  = 4'b1010;
  localparam logic [3:0] GOGO_REV  = 4'b0101;
  localparam logic [3:0] GOGO_SPIN = 4'b1001;

  // Motor enable patterns {left,right}
  localparam logic [1:0] RUN_OFF = 2'b00;
  localparam logic [1:0] RUN_ON  = 2'b11;

endpackage

// File: rtl/drive_sequencer_if.sv
// Sensor inputs and motor driver outputs of the drive sequencer, bundled as one port.
interface drive_sequencer_if;

  logic       ir_signal;  // raw IR receiver, active-low request
  logic       obst;       // raw obstacle sensor, active-high request
  logic [1:0] run;        // motor enables {left,right}
  logic [3:0] gogo;       // H-bridge direction bits
  logic       see;        // synchronised ir_signal
  logic       busy;       // high whenever not idle
  logic [2:0] state_o;    // current state encoding

  // The sequencer consumes sensor pins and drives the motor pins
  modport slave (
    input  ir_signal, obst,
    output run, gogo, see, busy, state_o
  );

  // The environment (sensors / bench) drives pins and observes the motor side
  modport master (
    output ir_signal, obst,
    input  run, gogo, see, busy, state_o
  );

endinterface

// File: rtl/drive_sequencer_sync_2ff.sv
// Two-flop synchroniser for an asynchronous sensor pin, with a configurable reset level
// so the pin reads as "inactive" straight out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,   // synchronous, active-low
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the pin through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages, forced to the inactive level during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/drive_sequencer.sv
// Motor drive scheduler: arbitrates IR forward runs against obstacle escapes (reverse then
// spin), inserts a brake gap before every direction reversal, and times all phases with a
// single down-counter. Outputs are decoded from the state register alone.
module drive_sequencer
  import car_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RUN_CYCLES  = 10000000,
  parameter int unsigned BACK_CYCLES = 5000000,
  parameter int unsigned TURN_CYCLES = 3000000,
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,   // synchronous, active-low
  drive_sequencer_if.slave  bus
);

  // Counter load values: a phase of LEN cycles loads LEN-1; LEN of 0 behaves as 1
  localparam logic [CNT_W-1:0] RUN_LOAD  = (RUN_CYCLES  == 0) ? '0 : CNT_W'(RUN_CYCLES  - 1);
  localparam logic [CNT_W-1:0] BACK_LOAD = (BACK_CYCLES == 0) ? '0 : CNT_W'(BACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = (TURN_CYCLES == 0) ? '0 : CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = (DEAD_CYCLES == 0) ? '0 : CNT_W'(DEAD_CYCLES - 1);

  logic ir_s;    // synchronised IR, low = request
  logic obst_s;  // synchronised obstacle, high = request

  sync_2ff #(.RST_VAL(1'b1)) u_sync_ir (
    .clk (clk),
    .rst (rst),
    .d   (bus.ir_signal),
    .q   (ir_s)
  );

  sync_2ff #(.RST_VAL(1'b0)) u_sync_obst (
    .clk (clk),
    .rst (rst),
    .d   (bus.obst),
    .q   (obst_s)
  );

  state_t           state_q, state_d;
  state_t           pend_q,  pend_d;   // where to go once the brake gap expires
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state, pending-target and phase-counter logic
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (obst_s) begin
          // motors are already off, so reverse needs no brake gap
          state_d = BACK;
          cnt_d   = BACK_LOAD;
        end else if (!ir_s) begin
          state_d = FWD;
          cnt_d   = RUN_LOAD;
        end
      end
      FWD: begin
        if (obst_s) begin
          state_d = DEAD;
          pend_d  = BACK;
          cnt_d   = DEAD_LOAD;
        end else if (!ir_s) begin
          cnt_d = RUN_LOAD;  // retrigger extends the run
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      DEAD: begin
        if (cnt_q == '0) begin
          case (pend_q)
            BACK: begin
              state_d = BACK;
              cnt_d   = BACK_LOAD;
            end
            TURN: begin
              state_d = TURN;
              cnt_d   = TURN_LOAD;
            end
            default: begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          endcase
        end
      end
      BACK: begin
        // escape in progress: all requests ignored
        if (cnt_q == '0) begin
          state_d = DEAD;
          pend_d  = TURN;
          cnt_d   = DEAD_LOAD;
        end
      end
      TURN: begin
        if (obst_s) begin
          state_d = DEAD;
          pend_d  = BACK;
          cnt_d   = DEAD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pending target and counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Motor pin decode from the registered state only
  always_comb begin
    bus.run  = RUN_OFF;
    bus.gogo = GOGO_OFF;
    case (state_q)
      FWD: begin
        bus.run  = RUN_ON;
        bus.gogo = GOGO_FWD;
      end
      BACK: begin
        bus.run  = RUN_ON;
        bus.gogo = GOGO_REV;
      end
      TURN: begin
        bus.run  = RUN_ON;
        bus.gogo = GOGO_SPIN;
      end
      default: begin
        bus.run  = RUN_OFF;
        bus.gogo = GOGO_OFF;
      end
    endcase
  end

  assign bus.see     = ir_s;
  assign bus.busy    = (state_q != IDLE);
  assign bus.state_o = state_q;

endmodule
